// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 32-bit ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic CIN_N_CARRY = 1'b0;
  localparam logic CIN_N_NONE  = 1'b1;

  localparam logic [SEL_W-1:0] SEL_ADD     = 4'b1001;
  localparam logic [SEL_W-1:0] SEL_SUB     = 4'b0110;
  localparam logic [SEL_W-1:0] SEL_XOR     = 4'b0110;
  localparam logic [SEL_W-1:0] SEL_DBL     = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_ONES    = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_MINUS_1 = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_AND     = 4'b1011;
  localparam logic [SEL_W-1:0] SEL_OR      = 4'b1110;
  localparam logic [SEL_W-1:0] SEL_NAND    = 4'b0100;

endpackage

// File: rtl/top_alu_16.sv
// 16-bit 74181-style ALU, active-high data, active-low carry in/out.
module top_alu_16
  import alu_seq_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              cin_n,
  output logic [HALF_W-1:0] f,
  output logic              cout_n
);

  logic [HALF_W-1:0] x;
  logic [HALF_W-1:0] y;
  logic [HALF_W:0]   sum;

  // Arithmetic result is x + y + carry; logic result is the carry-free xnor of the same terms.
  always_comb begin
    x      = a | (b & {HALF_W{sel[0]}}) | (~b & {HALF_W{sel[1]}});
    y      = (a & b & {HALF_W{sel[3]}}) | (a & ~b & {HALF_W{sel[2]}});
    sum    = {1'b0, x} + {1'b0, y} + {{HALF_W{1'b0}}, ~cin_n};
    f      = mode ? ~(x ^ y) : sum[HALF_W-1:0];
    cout_n = ~sum[HALF_W];
  end

endmodule

// File: rtl/alu_32_sequencer.sv
// Runs 32-bit (or 16-bit) commands through one 16-bit ALU as low then high halves,
// chaining the active-low carry, and returns result plus flags over valid/ready.
module alu_32_sequencer
  import alu_seq_pkg::*;
#(
  parameter bit W16_ZERO_UPPER = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_mode,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic              cmd_cin_n,
  input  logic              cmd_w16,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout_n,
  output logic              rsp_zero,
  output logic              rsp_neg
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, b_q;
  logic              mode_q, cin_n_q, w16_q;
  logic [SEL_W-1:0]  sel_q;
  logic [HALF_W-1:0] res_lo_q;
  logic              carry_lo_n_q;

  logic              accept;
  logic              cmd_ready_d, rsp_valid_d, rsp_load;
  logic [HALF_W-1:0] upper;
  logic [DATA_W-1:0] rsp_result_d;
  logic              rsp_cout_n_d, rsp_zero_d, rsp_neg_d;

  logic [HALF_W-1:0] alu_a, alu_b, alu_f;
  logic              alu_cin_n, alu_cout_n;

  // ALU inputs come only from registered command state.
  always_comb begin
    alu_a     = (state_q == HI) ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0];
    alu_b     = (state_q == HI) ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0];
    alu_cin_n = (state_q == HI) ? carry_lo_n_q : cin_n_q;
  end

  top_alu_16 u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (sel_q),
    .mode   (mode_q),
    .cin_n  (alu_cin_n),
    .f      (alu_f),
    .cout_n (alu_cout_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the values loaded into the registered outputs.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    upper        = '0;
    rsp_result_d = '0;
    rsp_zero_d   = 1'b0;
    rsp_neg_d    = 1'b0;
    rsp_cout_n_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        accept = cmd_valid && cmd_ready;
        if (accept) state_d = LO;
      end
      LO:      state_d = w16_q ? RESP : HI;
      HI:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_load    = (state_d == RESP) && (state_q != RESP);

    upper = W16_ZERO_UPPER ? '0 : a_q[DATA_W-1:HALF_W];
    if (w16_q) begin
      rsp_result_d = {upper, alu_f};
      rsp_zero_d   = (alu_f == '0);
    end else begin
      rsp_result_d = {alu_f, res_lo_q};
      rsp_zero_d   = ({alu_f, res_lo_q} == '0);
    end
    rsp_neg_d    = alu_f[HALF_W-1];
    rsp_cout_n_d = (mode_q == MODE_LOGIC) ? 1'b1 : alu_cout_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_cout_n   <= 1'b1;
      rsp_zero     <= 1'b0;
      rsp_neg      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= 1'b0;
      sel_q        <= '0;
      cin_n_q      <= 1'b0;
      w16_q        <= 1'b0;
      res_lo_q     <= '0;
      carry_lo_n_q <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        a_q     <= cmd_a;
        b_q     <= cmd_b;
        mode_q  <= cmd_mode;
        sel_q   <= cmd_sel;
        cin_n_q <= cmd_cin_n;
        w16_q   <= cmd_w16;
      end
      if (state_q == LO) begin
        res_lo_q     <= alu_f;
        carry_lo_n_q <= alu_cout_n;
      end
      if (rsp_load) begin
        rsp_result <= rsp_result_d;
        rsp_cout_n <= rsp_cout_n_d;
        rsp_zero   <= rsp_zero_d;
        rsp_neg    <= rsp_neg_d;
      end
    end
  end

endmodule
